// File: rtl/crc_check.sv
`default_nettype none
// ============================================================================
// Module  : crc_check
// Brief   : Receive-side CRC-16 (x^16+x^12+x^5+1) trailer checker for
//           sof/eof framed byte streams; pass/fail/length result per frame.
// Revision: 1.0
// ============================================================================
module crc_check #(
  parameter logic [15:0] CRC_INIT = 16'h0000,
  parameter int          LEN_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [7:0]       d,
  input  logic             d_valid,
  input  logic             sof,
  input  logic             eof,
  output logic [15:0]      crc_reg,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] c_len_max = '1;
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_len_two = LEN_W'(2);

  state_t           r_state;
  logic [15:0]      r_crc;
  logic [7:0]       r_h1;
  logic [7:0]       r_h2;
  logic [LEN_W-1:0] r_frame_len;
  logic             r_done;
  logic             r_crc_ok;
  logic             r_crc_err;
  logic             r_len_err;

  logic [LEN_W-1:0] w_len_inc;
  logic [15:0]      w_crc_next;
  logic             w_match;
  logic             w_len_bad;

  // Serial CRC over one byte, LSB first.
  function automatic logic [15:0] f_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] v_c;
    logic        v_fb;
    v_c = c;
    for (int i = 0; i < 8; i++) begin
      v_fb = v_c[15] ^ b[i];
      v_c  = {v_c[14:0], 1'b0} ^ (v_fb ? 16'h1021 : 16'h0000);
    end
    return v_c;
  endfunction

  function automatic logic [7:0] f_rev(input logic [7:0] b);
    logic [7:0] v_r;
    for (int i = 0; i < 8; i++) v_r[i] = b[7-i];
    return v_r;
  endfunction

  // The oldest held byte joins the CRC only once two younger bytes exist,
  // so the two trailer bytes never reach the CRC register.
  assign w_len_inc  = (r_frame_len == c_len_max) ? r_frame_len : r_frame_len + c_len_one;
  assign w_crc_next = (r_frame_len >= c_len_two) ? f_upd(r_crc, r_h2) : r_crc;
  assign w_match    = ({r_h1, d} == {~f_rev(w_crc_next[15:8]), ~f_rev(w_crc_next[7:0])});
  assign w_len_bad  = (r_frame_len < c_len_two) | (w_len_inc == c_len_max);

  always_ff @(posedge clk) begin
    if (!reset || init) begin
      r_state     <= S_IDLE;
      r_crc       <= CRC_INIT;
      r_h1        <= 8'h00;
      r_h2        <= 8'h00;
      r_frame_len <= '0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (d_valid) begin
        if (sof) begin
          r_crc       <= CRC_INIT;
          r_h1        <= d;
          r_frame_len <= c_len_one;
          r_crc_ok    <= 1'b0;
          r_crc_err   <= 1'b0;
          if (eof) begin
            r_len_err <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_len_err <= 1'b0;
            r_state   <= S_RECV;
          end
        end else if (r_state == S_RECV) begin
          r_crc       <= w_crc_next;
          r_h2        <= r_h1;
          r_h1        <= d;
          r_frame_len <= w_len_inc;
          if (eof) begin
            r_crc_ok  <= w_match & ~w_len_bad;
            r_crc_err <= ~w_match & ~w_len_bad;
            r_len_err <= w_len_bad;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
      end
    end
  end

  assign crc_reg   = r_crc;
  assign done      = r_done;
  assign crc_ok    = r_crc_ok;
  assign crc_err   = r_crc_err;
  assign len_err   = r_len_err;
  assign frame_len = r_frame_len;
  assign busy      = (r_state == S_RECV);

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`default_nettype none
// ============================================================================
// Module  : tb_crc_check
// Brief   : Directed and random-frame self-checking bench for crc_check.
// Revision: 1.0
// ============================================================================
module tb_crc_check;

  localparam int LEN_W = 11;

  logic             clk;
  logic             reset;
  logic             init;
  logic [7:0]       d;
  logic             d_valid;
  logic             sof;
  logic             eof;
  logic [15:0]      crc_reg;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [LEN_W-1:0] frame_len;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] frm[$];

  crc_check #(.CRC_INIT(16'h0000), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .init(init), .d(d), .d_valid(d_valid),
    .sof(sof), .eof(eof), .crc_reg(crc_reg), .done(done), .crc_ok(crc_ok),
    .crc_err(crc_err), .len_err(len_err), .frame_len(frame_len), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: bitwise CRC and transmitter trailer
  function automatic logic [15:0] m_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] v = c;
    for (int i = 0; i < 8; i++) begin
      if (v[15] ^ b[i]) v = {v[14:0], 1'b0} ^ 16'h1021;
      else              v = {v[14:0], 1'b0};
    end
    return v;
  endfunction

  function automatic logic [7:0] m_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input logic s, input logic e, input int gap);
    @(negedge clk);
    d = b; d_valid = 1'b1; sof = s; eof = e;
    @(posedge clk); #1;
    d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Sends frm[] as one frame; returns just after the eof edge (done cycle).
  task automatic run_frame(input int gap);
    for (int i = 0; i < frm.size(); i++)
      send(frm[i], i == 0, i == frm.size() - 1, (i == frm.size() - 1) ? 0 : gap);
  endtask

  task automatic chk_result(input string tag, input logic ok, input logic err,
                            input logic lerr, input int flen, input logic [15:0] crc);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ok"}, 32'(crc_ok), 32'(ok));
    chk({tag, "_err"}, 32'(crc_err), 32'(err));
    chk({tag, "_lenerr"}, 32'(len_err), 32'(lerr));
    chk({tag, "_len"}, 32'(frame_len), 32'(flen));
    chk({tag, "_crc"}, 32'(crc_reg), 32'(crc));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ok_held"}, 32'(crc_ok), 32'(ok));
  endtask

  initial begin
    int base;
    int plen;
    logic [15:0] r;
    reset = 1'b0; init = 1'b0; d = 8'h00; d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: reset state, stray bytes without sof ignored
    send(8'h12, 1'b0, 1'b0, 0);
    send(8'h34, 1'b0, 1'b1, 1);
    chk("rst_crc", 32'(crc_reg), 32'h0);
    chk("rst_outs", {27'b0, done, crc_ok, crc_err, len_err, busy}, 32'h0);
    chk("rst_len", 32'(frame_len), 32'h0);
    chk("rst_donecnt", 32'(done_cnt), 32'h0);

    // 2: good minimal frame back-to-back
    frm = '{8'h00, 8'hFF, 8'hFF};
    run_frame(0);
    chk_result("t2", 1'b1, 1'b0, 1'b0, 3, 16'h0000);

    // 3: corrupted trailer
    frm = '{8'h00, 8'hFF, 8'hFE};
    run_frame(0);
    chk_result("t3", 1'b0, 1'b1, 1'b0, 3, 16'h0000);

    // 4: same as 2 with idle gaps
    frm = '{8'h00, 8'hFF, 8'hFF};
    send(frm[0], 1'b1, 1'b0, 3);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_okclr", 32'(crc_err), 32'd0);
    send(frm[1], 1'b0, 1'b0, 3);
    send(frm[2], 1'b0, 1'b1, 0);
    chk_result("t4", 1'b1, 1'b0, 1'b0, 3, 16'h0000);

    // 5: one- and two-byte frames
    frm = '{8'h55};
    run_frame(0);
    chk_result("t5a", 1'b0, 1'b0, 1'b1, 1, 16'h0000);
    frm = '{8'h12, 8'h34};
    run_frame(0);
    chk_result("t5b", 1'b0, 1'b0, 1'b1, 2, 16'h0000);

    // 6: abort by new sof, only one done
    base = done_cnt;
    frm = '{8'hAA, 8'hBB, 8'h00, 8'hFF, 8'hFF};
    send(frm[0], 1'b1, 1'b0, 0);
    send(frm[1], 1'b0, 1'b0, 0);
    send(frm[2], 1'b1, 1'b0, 0);
    send(frm[3], 1'b0, 1'b0, 0);
    send(frm[4], 1'b0, 1'b1, 0);
    chk_result("t6", 1'b1, 1'b0, 1'b0, 3, 16'h0000);
    chk("t6_onedone", 32'(done_cnt - base), 32'd1);

    // init mid-frame discards the frame silently
    base = done_cnt;
    send(8'h11, 1'b1, 1'b0, 0);
    send(8'h22, 1'b0, 1'b0, 0);
    @(negedge clk); init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
    send(8'h33, 1'b0, 1'b1, 2);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_len", 32'(frame_len), 32'd0);
    chk("init_nodone", 32'(done_cnt - base), 32'd0);

    // random frames through transmitter model
    for (int n = 0; n < 200; n++) begin
      plen = $urandom_range(1, 64);
      frm.delete();
      r = 16'h0000;
      for (int i = 0; i < plen; i++) begin
        frm.push_back(8'($urandom_range(0, 255)));
        r = m_upd(r, frm[i]);
      end
      frm.push_back(~m_rev(r[15:8]));
      frm.push_back(~m_rev(r[7:0]));
      run_frame($urandom_range(0, 1));
      chk("rnd_done", 32'(done), 32'd1);
      chk("rnd_ok", 32'(crc_ok), 32'd1);
      chk("rnd_crc", 32'(crc_reg), 32'(r));
      chk("rnd_len", 32'(frame_len), 32'(plen + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
